// File: rtl/core_run_ctrl.sv
// Run sequencer around the 9-bit core: host load -> core reset pulse -> run -> stream a result window back out.
// Optional RUN watchdog is compiled in with `define CORE_RUN_TIMEOUT_EN.
module core_run_ctrl #(
  parameter int AW         = 8,
  parameter int DW         = 8,
  parameter int RST_CYCLES = 2,
  parameter int RES_BASE   = 0,
  parameter int RES_LEN    = 4,
  parameter int MAX_CYCLES = 4096
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          start,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_last,
  output logic          core_reset,
  input  logic          core_done,
  output logic          mem_own,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdat,
  input  logic [DW-1:0] mem_rdat,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_data,
  output logic          res_last,
  output logic          busy,
  output logic          timeout,
  output logic [2:0]    state_dbg
);

  // Handshakes: a byte moves on any cycle where valid&ready are both 1; valid never waits on ready,
  // and a presented result byte stays put until taken.

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LOAD       = 3'd1,
    S_RESET_CORE = 3'd2,
    S_RUN        = 3'd3,
    S_DRAIN      = 3'd4
  } state_t;

  localparam logic [31:0] RST_LAST = 32'(RST_CYCLES - 1);
  localparam logic [AW:0] LEN_A    = (AW+1)'(RES_LEN);
  localparam logic [AW:0] LAST_A   = (AW+1)'(RES_LEN - 1);
  localparam logic [AW-1:0] BASE_A = AW'(RES_BASE);

  state_t      state, next_state;
  logic [31:0] cnt;
  logic [AW:0] idx;
  logic        fetch;
  logic        wd_limit;
  logic        wd_hit;

`ifdef CORE_RUN_TIMEOUT_EN
  localparam logic [31:0] MAX_LAST = 32'(MAX_CYCLES - 1);
  assign wd_limit = (cnt == MAX_LAST);
`else
  assign wd_limit = 1'b0;
`endif

  always_comb begin
    next_state = state;
    fetch      = 1'b0;
    wd_hit     = 1'b0;
    case (state)
      S_IDLE:       if (start) next_state = S_LOAD;
      S_LOAD:       if (ld_valid && ld_last) next_state = S_RESET_CORE;
      S_RESET_CORE: if (cnt == RST_LAST) next_state = S_RUN;
      S_RUN: begin
        // core_done takes priority over a watchdog expiry in the same cycle
        if (core_done) begin
          next_state = S_DRAIN;
        end else if (wd_limit) begin
          wd_hit     = 1'b1;
          next_state = S_DRAIN;
        end
      end
      S_DRAIN: begin
        fetch = (idx != LEN_A) && (!res_valid || res_ready);
        if (res_valid && res_ready && res_last) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state      <= S_IDLE;
      core_reset <= 1'b1;
      mem_own    <= 1'b1;
      busy       <= 1'b0;
      cnt        <= '0;
      idx        <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_last   <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state      <= next_state;
      core_reset <= (next_state != S_RUN);
      mem_own    <= (next_state != S_RUN);
      busy       <= (next_state != S_IDLE);

      // Counts cycles spent in RESET_CORE / RUN; restarts at every state change.
      if ((next_state == state) && (state == S_RESET_CORE || state == S_RUN))
        cnt <= cnt + 32'd1;
      else
        cnt <= '0;

      if (state != S_DRAIN)
        idx <= '0;
      else if (fetch)
        idx <= idx + 1'b1;

      if (fetch) begin
        res_valid <= 1'b1;
        res_data  <= mem_rdat;
        res_last  <= (idx == LAST_A);
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
        res_last  <= 1'b0;
      end

`ifdef CORE_RUN_TIMEOUT_EN
      if (state == S_IDLE && start)
        timeout <= 1'b0;
      else if (wd_hit)
        timeout <= 1'b1;
`else
      timeout <= 1'b0;
`endif
    end
  end

  // Load bytes pass straight through to memory in the cycle they are accepted.
  assign ld_ready  = (state == S_LOAD);
  assign mem_wr_en = (state == S_LOAD) && ld_valid;
  assign mem_addr  = (state == S_LOAD) ? ld_addr : BASE_A + idx[AW-1:0];
  assign mem_wdat  = (state == S_LOAD) ? ld_data : '0;
  assign state_dbg = state;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Bench for core_run_ctrl: two instances (result window at 0x00 and at 0xFE) share one stimulus stream,
// each with its own memory; a reference copy of memory predicts the streamed result bytes.
module tb_core_run_ctrl;

  localparam int RES_LEN = 4;
  localparam int RST_CYC = 2;
  localparam logic [7:0] BASE_A = 8'h00;
  localparam logic [7:0] BASE_B = 8'hFE;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, ld_valid, ld_last, core_done, res_ready;
  logic [7:0] ld_addr, ld_data;

  logic       ld_ready_a, core_reset_a, mem_own_a, mem_wr_en_a, res_valid_a, res_last_a, busy_a, timeout_a;
  logic       ld_ready_b, core_reset_b, mem_own_b, mem_wr_en_b, res_valid_b, res_last_b, busy_b, timeout_b;
  logic [7:0] mem_addr_a, mem_wdat_a, mem_rdat_a, res_data_a;
  logic [7:0] mem_addr_b, mem_wdat_b, mem_rdat_b, res_data_b;
  logic [2:0] state_dbg_a, state_dbg_b;

  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];
  logic [7:0] ref_a [256];
  logic [7:0] ref_b [256];

  assign mem_rdat_a = mem_a[mem_addr_a];
  assign mem_rdat_b = mem_b[mem_addr_b];

  core_run_ctrl #(.AW(8), .DW(8), .RST_CYCLES(RST_CYC), .RES_BASE(0), .RES_LEN(RES_LEN), .MAX_CYCLES(16)) dut_a (
    .Clk(clk), .Reset(rst_n), .start(start), .ld_valid(ld_valid), .ld_ready(ld_ready_a),
    .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last), .core_reset(core_reset_a),
    .core_done(core_done), .mem_own(mem_own_a), .mem_wr_en(mem_wr_en_a), .mem_addr(mem_addr_a),
    .mem_wdat(mem_wdat_a), .mem_rdat(mem_rdat_a), .res_valid(res_valid_a), .res_ready(res_ready),
    .res_data(res_data_a), .res_last(res_last_a), .busy(busy_a), .timeout(timeout_a), .state_dbg(state_dbg_a)
  );

  core_run_ctrl #(.AW(8), .DW(8), .RST_CYCLES(RST_CYC), .RES_BASE(254), .RES_LEN(RES_LEN), .MAX_CYCLES(16)) dut_b (
    .Clk(clk), .Reset(rst_n), .start(start), .ld_valid(ld_valid), .ld_ready(ld_ready_b),
    .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last), .core_reset(core_reset_b),
    .core_done(core_done), .mem_own(mem_own_b), .mem_wr_en(mem_wr_en_b), .mem_addr(mem_addr_b),
    .mem_wdat(mem_wdat_b), .mem_rdat(mem_rdat_b), .res_valid(res_valid_b), .res_ready(res_ready),
    .res_data(res_data_b), .res_last(res_last_b), .busy(busy_b), .timeout(timeout_b), .state_dbg(state_dbg_b)
  );

  int n_chk  = 0;
  int n_pass = 0;
  logic [15:0] exp_q[$];  // {byte from instance b window, byte from instance a window}

  typedef struct {
    logic       valid;
    logic [7:0] addr;
    logic [7:0] data;
    logic       last;
    logic       exp_wr;
  } ld_vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  // Advance one clock; the memories capture whatever write the instances present at the edge.
  task automatic tick();
    logic       we_a, we_b;
    logic [7:0] wa_a, wa_b, wd_a, wd_b;
    #1;
    we_a = mem_own_a && mem_wr_en_a; wa_a = mem_addr_a; wd_a = mem_wdat_a;
    we_b = mem_own_b && mem_wr_en_b; wa_b = mem_addr_b; wd_b = mem_wdat_b;
    @(posedge clk);
    if (we_a === 1'b1) mem_a[wa_a] = wd_a;
    if (we_b === 1'b1) mem_b[wa_b] = wd_b;
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", busy_a, 1);
    chk("start_ld_ready", ld_ready_a, 1);
  endtask

  task automatic load_byte(input logic [7:0] addr, input logic [7:0] data, input logic last, input int stalls);
    for (int s = 0; s < stalls; s++) begin
      ld_valid = 1'b0; ld_addr = 8'($urandom); ld_last = 1'($urandom);
      #1;
      chk("stall_ld_ready", ld_ready_a, 1);
      chk("stall_wr_en", mem_wr_en_a, 0);
      tick();
    end
    ld_valid = 1'b1; ld_addr = addr; ld_data = data; ld_last = last;
    #1;
    chk("ld_ready_b", ld_ready_b, 1);
    chk("ld_wr_en", mem_wr_en_a, 1);
    chk("ld_addr", mem_addr_a, addr);
    chk("ld_wdat", mem_wdat_a, data);
    ref_a[addr] = data;
    ref_b[addr] = data;
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic wait_reset_core();
    int n = 0;
    while (core_reset_a && n < 20) begin
      n++;
      tick();
    end
    chk("core_reset_cycles", n, RST_CYC);
  endtask

  task automatic run_core(input int r, input logic noise);
    for (int i = 0; i < r; i++) begin
      core_done = (i == r - 1);
      start = noise && ($urandom_range(0, 3) == 0);
      #1;
      chk("run_core_reset", core_reset_a, 0);
      chk("run_mem_own", mem_own_b, 0);
      chk("run_wr_en", mem_wr_en_a, 0);
      chk("run_timeout", timeout_a, 0);
      tick();
    end
    core_done = 1'b0;
    start = 1'b0;
    chk("drain_core_reset", core_reset_b, 1);
    chk("drain_mem_own", mem_own_a, 1);
    chk("drain_busy", busy_a, 1);
  endtask

  // mode 0: ready held high, 1: ready toggles, 2: random ready
  task automatic drain(input int mode, output int cycles);
    logic       held = 1'b0;
    logic [7:0] held_d = 8'h00;
    for (int i = 0; i < RES_LEN; i++)
      exp_q.push_back({ref_b[8'(BASE_B + 8'(i))], ref_a[8'(BASE_A + 8'(i))]});
    cycles = 0;
    while (exp_q.size() > 0 && cycles < 64) begin
      res_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (cycles % 2 == 0) : 1'($urandom_range(0, 1));
      #1;
      cycles++;
      if (res_valid_a) begin
        if (held) chk("stall_hold", res_data_a, held_d);
        chk("res_valid_b", res_valid_b, 1);
        chk("res_data_a", res_data_a, exp_q[0][7:0]);
        chk("res_data_b", res_data_b, exp_q[0][15:8]);
        chk("res_last_a", res_last_a, exp_q.size() == 1);
        chk("res_last_b", res_last_b, exp_q.size() == 1);
        if (res_ready) begin
          void'(exp_q.pop_front());
          held = 1'b0;
        end else begin
          held = 1'b1;
          held_d = res_data_a;
        end
      end
      tick();
    end
    chk("drain_complete", exp_q.size(), 0);
    exp_q.delete();
    res_ready = 1'b0;
    chk("idle_busy", busy_b, 0);
    chk("idle_res_valid", res_valid_a, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    ld_vec_t tbl[5];
    int      cyc;
    int      nwr;
    int      nb;
    int      n;
    int      r;

    tbl[0] = '{1'b1, 8'h00, 8'h11, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 8'h07, 8'hAA, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 8'h01, 8'h22, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 8'h03, 8'h55, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 8'h02, 8'h33, 1'b1, 1'b1};

    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 8'($urandom); ref_a[i] = mem_a[i];
      mem_b[i] = 8'($urandom); ref_b[i] = mem_b[i];
    end
    rst_n = 1'b0; start = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_data = '0; ld_last = 1'b0;
    core_done = 1'b0; res_ready = 1'b0;

    // Reset values
    #12;
    chk("rst_core_reset", core_reset_a, 1);
    chk("rst_mem_own", mem_own_a, 1);
    chk("rst_ld_ready", ld_ready_a, 0);
    chk("rst_wr_en", mem_wr_en_b, 0);
    chk("rst_res_valid", res_valid_a, 0);
    chk("rst_res_last", res_last_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_timeout", timeout_b, 0);
    chk("rst_state", state_dbg_b, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    chk("idle_ld_ready", ld_ready_a, 0);

    // Directed: three table-driven loads with stalls, ten RUN cycles, full-rate drain
    pulse_start();
    nwr = 0;
    for (int i = 0; i < 5; i++) begin
      ld_valid = tbl[i].valid; ld_addr = tbl[i].addr; ld_data = tbl[i].data; ld_last = tbl[i].last;
      #1;
      chk("tbl_ld_ready", ld_ready_a, 1);
      chk("tbl_wr_en", mem_wr_en_a, tbl[i].exp_wr);
      chk("tbl_addr", mem_addr_a, tbl[i].addr);
      chk("tbl_wdat", mem_wdat_a, tbl[i].data);
      if (mem_wr_en_a) nwr++;
      if (tbl[i].valid) begin
        ref_a[tbl[i].addr] = tbl[i].data;
        ref_b[tbl[i].addr] = tbl[i].data;
      end
      tick();
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    chk("tbl_write_count", nwr, 3);
    wait_reset_core();
    run_core(10, 1'b0);
    drain(0, cyc);
    chk("drain_throughput", cyc, RES_LEN + 1);
    chk("mem_a_0", mem_a[0], 8'h11);
    chk("mem_a_2", mem_a[2], 8'h33);

    // Toggling ready, core_done in the first RUN cycle
    pulse_start();
    load_byte(8'h03, 8'h5C, 1'b0, 0);
    load_byte(8'hFF, 8'hA7, 1'b1, 1);
    wait_reset_core();
    run_core(1, 1'b0);
    drain(1, cyc);

    // Randomized rounds against the reference memory
    for (int k = 0; k < 8; k++) begin
      pulse_start();
      nb = $urandom_range(1, 6);
      for (int j = 0; j < nb; j++) begin
        r = $urandom_range(0, 9);
        load_byte((r < 6) ? 8'(r) : 8'(r + 8'hF6), 8'($urandom), (j == nb - 1), $urandom_range(0, 2));
      end
      wait_reset_core();
      run_core($urandom_range(1, 16), 1'b1);
      drain(2, cyc);
    end

`ifdef CORE_RUN_TIMEOUT_EN
    // Watchdog: no core_done, RUN ends after 16 cycles with the sticky flag set
    pulse_start();
    load_byte(8'h01, 8'h6B, 1'b1, 0);
    wait_reset_core();
    n = 0;
    core_done = 1'b0;
    while (!core_reset_a && n < 40) begin
      n++;
      tick();
    end
    chk("wd_run_cycles", n, 16);
    chk("wd_timeout", timeout_a, 1);
    drain(0, cyc);
    chk("wd_sticky", timeout_b, 1);
    pulse_start();
    chk("wd_cleared", timeout_a, 0);
    load_byte(8'h00, 8'h4E, 1'b1, 0);
    wait_reset_core();
    run_core(3, 1'b0);
    drain(0, cyc);
`endif

    // Asynchronous reset in the middle of RUN, then a clean restart
    pulse_start();
    load_byte(8'h02, 8'h9D, 1'b1, 0);
    wait_reset_core();
    core_done = 1'b0;
    repeat (3) tick();
    chk("mid_run_state", core_reset_a, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_core_reset", core_reset_a, 1);
    chk("async_busy", busy_a, 0);
    chk("async_mem_own", mem_own_b, 1);
    chk("async_state", state_dbg_a, 0);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    pulse_start();
    chk("restart_core_reset", core_reset_a, 1);
    load_byte(8'h01, 8'hC4, 1'b1, 0);
    wait_reset_core();
    run_core(2, 1'b0);
    drain(0, cyc);
    chk("restart_throughput", cyc, RES_LEN + 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
